// File: rtl/fpu_mul_exp_pkg.sv
// Shared types and format helpers for the multiply-pipe exponent datapath.
// Widths are passed in so one package serves any EXP_W/SNG_W pairing.
package fpu_mul_exp_pkg;

  typedef enum logic {SNG = 1'b0, DBL = 1'b1} fmt_e;

  typedef enum logic [1:0] {NRM = 2'b00, ZERO = 2'b01, INF = 2'b10} spec_e;

  function automatic int bias(fmt_e fmt, int exp_w, int sng_w);
    return (fmt == DBL) ? (1 << (exp_w - 1)) - 1 : (1 << (sng_w - 1)) - 1;
  endfunction

  function automatic int emax(fmt_e fmt, int exp_w, int sng_w);
    return (fmt == DBL) ? (1 << exp_w) - 1 : (1 << sng_w) - 1;
  endfunction

endpackage

// File: rtl/fpu_mul_exp_pipe_if.sv
// Operand, sideband and result bundle for the multiply exponent pipe.
interface fpu_mul_exp_pipe_if #(
  parameter int EXP_W = 11,
  parameter int LZ_W  = 7
);
  logic             step;
  logic             in_vld;
  logic             in_fmt;
  logic [1:0]       in_spec;
  logic             in_to_inf;
  logic [EXP_W-1:0] in_exp1;
  logic [EXP_W-1:0] in_exp2;
  logic [LZ_W-1:0]  in_lz;
  logic             in_shl;
  logic             in_rnd_cout;
  logic             out_vld;
  logic [EXP_W-1:0] out_exp;
  logic             out_of;
  logic             out_uf;

  modport master (
    output step, in_vld, in_fmt, in_spec, in_to_inf, in_exp1, in_exp2,
           in_lz, in_shl, in_rnd_cout,
    input  out_vld, out_exp, out_of, out_uf
  );

  modport slave (
    input  step, in_vld, in_fmt, in_spec, in_to_inf, in_exp1, in_exp2,
           in_lz, in_shl, in_rnd_cout,
    output out_vld, out_exp, out_of, out_uf
  );
endinterface

// File: rtl/fpu_mul_exp_stage.sv
// One pipe register: loads only on step, clears asynchronously so every
// stage (and its valid) drops to a bubble the moment reset asserts.
module fpu_mul_exp_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (step) q <= d;
  end

endmodule

// File: rtl/fpu_mul_exp_pipe.sv
// Multiply exponent pipe: S1, S2, DLY delay stages, NORM, INC and OUT, with
// lz/shl/rounding-carry sidebands joining the token at NORM/INC/OUT.
module fpu_mul_exp_pipe
  import fpu_mul_exp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int SNG_W = 8,
  parameter int LZ_W  = 7,
  parameter int DLY   = 2
) (
  input  logic               rclk,
  input  logic               arst,
  fpu_mul_exp_pipe_if.slave  bus
);

  localparam int IW = EXP_W + 3;

  typedef struct packed {
    logic                 vld;
    fmt_e                 fmt;
    spec_e                spec;
    logic                 to_inf;
    logic                 uf;
    logic signed [IW-1:0] e;
  } token_t;

  typedef struct packed {
    token_t               tok;
    logic signed [IW-1:0] e2;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic [EXP_W-1:0] exp;
    logic             of;
    logic             uf;
  } out_t;

  // Singles live in the low SNG_W bits; a zero exponent is a denormal and
  // behaves as exponent 1.
  function automatic logic signed [IW-1:0] prep_op(logic [EXP_W-1:0] raw, fmt_e fmt);
    logic [EXP_W-1:0] v;
    v = (fmt == DBL) ? raw : (raw & EXP_W'((1 << SNG_W) - 1));
    if (v == '0) v = EXP_W'(1);
    return $signed({3'b000, v});
  endfunction

  s1_t    s1_d, s1_q;
  token_t s2_d, s2_q, norm_d, norm_q, inc_d, inc_q;
  token_t dly_q [DLY+1];
  out_t   out_d, out_q;
  logic signed [IW-1:0] e_norm, e_fin, emax_e;
  fmt_e   in_fmt_e;

  always_comb begin
    in_fmt_e       = fmt_e'(bus.in_fmt);
    s1_d           = '0;
    s1_d.tok.vld   = bus.in_vld;
    s1_d.tok.fmt   = in_fmt_e;
    s1_d.tok.spec  = spec_e'(bus.in_spec);
    s1_d.tok.to_inf = bus.in_to_inf;
    s1_d.tok.e     = prep_op(bus.in_exp1, in_fmt_e);
    s1_d.e2        = prep_op(bus.in_exp2, in_fmt_e);
  end

  always_comb begin
    s2_d   = s1_q.tok;
    s2_d.e = s1_q.tok.e + s1_q.e2 - IW'(bias(s1_q.tok.fmt, EXP_W, SNG_W));
  end

  fpu_mul_exp_stage #(.W($bits(s1_t)))   u_s1 (.clk(rclk), .rst(arst), .step(bus.step), .d(s1_d), .q(s1_q));
  fpu_mul_exp_stage #(.W($bits(token_t))) u_s2 (.clk(rclk), .rst(arst), .step(bus.step), .d(s2_d), .q(s2_q));

  assign dly_q[0] = s2_q;

  for (genvar i = 0; i < DLY; i++) begin : g_dly
    fpu_mul_exp_stage #(.W($bits(token_t))) u_d (
      .clk(rclk), .rst(arst), .step(bus.step), .d(dly_q[i]), .q(dly_q[i+1])
    );
  end

  // Underflow clamps to zero and freezes the token so later +1s cannot
  // resurrect it.
  always_comb begin
    norm_d = dly_q[DLY];
    e_norm = dly_q[DLY].e - $signed({{(IW-LZ_W){1'b0}}, bus.in_lz});
    norm_d.e = e_norm;
    if (e_norm[IW-1] || e_norm == '0) begin
      norm_d.e  = '0;
      norm_d.uf = 1'b1;
    end
  end

  always_comb begin
    inc_d = norm_q;
    if (!norm_q.uf) inc_d.e = norm_q.e + $signed({{(IW-1){1'b0}}, bus.in_shl});
  end

  fpu_mul_exp_stage #(.W($bits(token_t))) u_norm (.clk(rclk), .rst(arst), .step(bus.step), .d(norm_d), .q(norm_q));
  fpu_mul_exp_stage #(.W($bits(token_t))) u_inc  (.clk(rclk), .rst(arst), .step(bus.step), .d(inc_d),  .q(inc_q));

  // Special operands bypass the arithmetic; bubbles leave every output at 0.
  always_comb begin
    out_d  = '0;
    emax_e = IW'(emax(inc_q.fmt, EXP_W, SNG_W));
    e_fin  = inc_q.e;
    if (!inc_q.uf) e_fin = inc_q.e + $signed({{(IW-1){1'b0}}, bus.in_rnd_cout});
    if (inc_q.vld) begin
      out_d.vld = 1'b1;
      if (inc_q.spec == ZERO) begin
        out_d.exp = '0;
      end else if (inc_q.spec == INF) begin
        out_d.exp = emax_e[EXP_W-1:0];
      end else if (inc_q.uf) begin
        out_d.uf = 1'b1;
      end else if (e_fin >= emax_e) begin
        out_d.of  = 1'b1;
        out_d.exp = inc_q.to_inf ? emax_e[EXP_W-1:0] : EXP_W'(emax_e - 1);
      end else begin
        out_d.exp = e_fin[EXP_W-1:0];
      end
    end
  end

  fpu_mul_exp_stage #(.W($bits(out_t))) u_out (.clk(rclk), .rst(arst), .step(bus.step), .d(out_d), .q(out_q));

  assign bus.out_vld = out_q.vld;
  assign bus.out_exp = out_q.exp;
  assign bus.out_of  = out_q.of;
  assign bus.out_uf  = out_q.uf;

endmodule

// File: tb/tb_fpu_mul_exp_pipe.sv
// Table-driven scoreboard bench for fpu_mul_exp_pipe: vectors carry hand
// derived results; sidebands are fed to whichever token sits at each stage.
module tb_fpu_mul_exp_pipe;
  import fpu_mul_exp_pkg::*;

  localparam int EXP_W = 11;
  localparam int SNG_W = 8;
  localparam int LZ_W  = 7;
  localparam int DLY   = 2;
  localparam int LAT   = DLY + 5;
  localparam int NV    = 15;

  typedef struct {
    logic             fmt;
    logic [1:0]       spec;
    logic             to_inf;
    logic [EXP_W-1:0] e1;
    logic [EXP_W-1:0] e2;
    logic [LZ_W-1:0]  lz;
    logic             shl;
    logic             cout;
    logic [EXP_W-1:0] x_exp;
    logic             x_of;
    logic             x_uf;
  } vec_t;

  typedef struct {
    int idx;
    int due;
  } sb_t;

  logic rclk = 1'b0;
  logic arst;
  always #5 rclk = ~rclk;

  fpu_mul_exp_pipe_if #(.EXP_W(EXP_W), .LZ_W(LZ_W)) bus ();

  fpu_mul_exp_pipe #(.EXP_W(EXP_W), .SNG_W(SNG_W), .LZ_W(LZ_W), .DLY(DLY)) dut (
    .rclk(rclk),
    .arst(arst),
    .bus(bus)
  );

  vec_t vecs [NV];
  sb_t  sb_q [$];
  int   hist [1024];
  int   edge_n     = 0;
  int   hist_floor = 0;
  int   checks     = 0;
  int   errors     = 0;

  logic             x_vld;
  logic [EXP_W-1:0] x_exp;
  logic             x_of;
  logic             x_uf;

  task automatic set_vec(input int i, input logic fmt, input logic [1:0] spec, input logic to_inf,
                         input logic [EXP_W-1:0] e1, input logic [EXP_W-1:0] e2,
                         input logic [LZ_W-1:0] lz, input logic shl, input logic cout,
                         input logic [EXP_W-1:0] xe, input logic xo, input logic xu);
    vecs[i] = '{fmt, spec, to_inf, e1, e2, lz, shl, cout, xe, xo, xu};
  endtask

  task automatic check_val(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, " out_vld"}, int'(bus.out_vld), int'(x_vld));
    check_val({tag, " out_exp"}, int'(bus.out_exp), int'(x_exp));
    check_val({tag, " out_of"},  int'(bus.out_of),  int'(x_of));
    check_val({tag, " out_uf"},  int'(bus.out_uf),  int'(x_uf));
  endtask

  function automatic int tok_at(input int e);
    if (e <= hist_floor || e < 1) return -1;
    return hist[e];
  endfunction

  // After a step edge the expected output is the scoreboard head if it is
  // due on this edge, otherwise a bubble; a stalled cycle must hold.
  task automatic checkOutput(input logic st);
    sb_t   s;
    string tag;
    if (st) begin
      if (sb_q.size() > 0 && sb_q[0].due == edge_n) begin
        s     = sb_q.pop_front();
        x_vld = 1'b1;
        x_exp = vecs[s.idx].x_exp;
        x_of  = vecs[s.idx].x_of;
        x_uf  = vecs[s.idx].x_uf;
        tag   = $sformatf("vec%0d@edge%0d", s.idx, edge_n);
      end else begin
        x_vld = 1'b0;
        x_exp = '0;
        x_of  = 1'b0;
        x_uf  = 1'b0;
        tag   = $sformatf("bubble@edge%0d", edge_n);
      end
    end else begin
      tag = $sformatf("hold@edge%0d", edge_n);
    end
    compare_all(tag);
  endtask

  task automatic applyStimulus(input int idx, input logic st);
    int nxt;
    int t;
    nxt      = edge_n + 1;
    bus.step = st;
    if (idx >= 0) begin
      bus.in_vld    = 1'b1;
      bus.in_fmt    = vecs[idx].fmt;
      bus.in_spec   = vecs[idx].spec;
      bus.in_to_inf = vecs[idx].to_inf;
      bus.in_exp1   = vecs[idx].e1;
      bus.in_exp2   = vecs[idx].e2;
    end else begin
      bus.in_vld    = !st;
      bus.in_fmt    = 1'($urandom);
      bus.in_spec   = 2'($urandom);
      bus.in_to_inf = 1'($urandom);
      bus.in_exp1   = EXP_W'($urandom);
      bus.in_exp2   = EXP_W'($urandom);
    end
    bus.in_lz       = LZ_W'($urandom);
    bus.in_shl      = 1'($urandom);
    bus.in_rnd_cout = 1'($urandom);
    if (st) begin
      t = tok_at(nxt - (DLY + 2));
      if (t >= 0) bus.in_lz = vecs[t].lz;
      t = tok_at(nxt - (DLY + 3));
      if (t >= 0) bus.in_shl = vecs[t].shl;
      t = tok_at(nxt - (DLY + 4));
      if (t >= 0) bus.in_rnd_cout = vecs[t].cout;
    end
    @(posedge rclk);
    if (st) begin
      edge_n++;
      hist[edge_n] = idx;
      if (idx >= 0) sb_q.push_back('{idx, edge_n + LAT - 1});
    end
    #1;
    checkOutput(st);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) hist[i] = -1;
    //        i   fmt   spec   inf   e1      e2      lz     shl   cout  x_exp   of    uf
    set_vec(0,  1'b1, 2'b00, 1'b0, 11'h400, 11'h3FF, 7'd0, 1'b0, 1'b0, 11'h400, 1'b0, 1'b0);
    set_vec(1,  1'b0, 2'b00, 1'b0, 11'h080, 11'h080, 7'd0, 1'b0, 1'b0, 11'h081, 1'b0, 1'b0);
    set_vec(2,  1'b1, 2'b00, 1'b0, 11'h3FF, 11'h3FF, 7'd3, 1'b1, 1'b1, 11'h3FE, 1'b0, 1'b0);
    set_vec(3,  1'b1, 2'b00, 1'b1, 11'h7FE, 11'h7FE, 7'd0, 1'b0, 1'b0, 11'h7FF, 1'b1, 1'b0);
    set_vec(4,  1'b1, 2'b00, 1'b0, 11'h7FE, 11'h7FE, 7'd0, 1'b0, 1'b0, 11'h7FE, 1'b1, 1'b0);
    set_vec(5,  1'b1, 2'b00, 1'b0, 11'h3FF, 11'h3FF, 7'd0, 1'b0, 1'b1, 11'h400, 1'b0, 1'b0);
    set_vec(6,  1'b1, 2'b00, 1'b1, 11'h7FE, 11'h3FF, 7'd0, 1'b0, 1'b1, 11'h7FF, 1'b1, 1'b0);
    set_vec(7,  1'b1, 2'b00, 1'b0, 11'h001, 11'h001, 7'd0, 1'b1, 1'b1, 11'h000, 1'b0, 1'b1);
    set_vec(8,  1'b0, 2'b10, 1'b0, 11'h123, 11'h045, 7'd5, 1'b1, 1'b1, 11'h0FF, 1'b0, 1'b0);
    set_vec(9,  1'b1, 2'b01, 1'b1, 11'h7FE, 11'h7FE, 7'd0, 1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    set_vec(10, 1'b0, 2'b00, 1'b0, 11'h700, 11'h0FE, 7'd0, 1'b0, 1'b0, 11'h080, 1'b0, 1'b0);
    set_vec(11, 1'b0, 2'b00, 1'b0, 11'h0FE, 11'h0FE, 7'd0, 1'b0, 1'b0, 11'h0FE, 1'b1, 1'b0);
    set_vec(12, 1'b0, 2'b00, 1'b0, 11'h07F, 11'h001, 7'd1, 1'b1, 1'b0, 11'h000, 1'b0, 1'b1);
    set_vec(13, 1'b1, 2'b00, 1'b0, 11'h3FF, 11'h001, 7'd0, 1'b0, 1'b0, 11'h001, 1'b0, 1'b0);
    set_vec(14, 1'b1, 2'b00, 1'b0, 11'h7FE, 11'h3FF, 7'd1, 1'b1, 1'b0, 11'h7FE, 1'b0, 1'b0);

    arst = 1'b1;
    bus.step = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_fmt = 1'b0;
    bus.in_spec = 2'b00;
    bus.in_to_inf = 1'b0;
    bus.in_exp1 = '0;
    bus.in_exp2 = '0;
    bus.in_lz = '0;
    bus.in_shl = 1'b0;
    bus.in_rnd_cout = 1'b0;
    x_vld = 1'b0;
    x_exp = '0;
    x_of  = 1'b0;
    x_uf  = 1'b0;
    repeat (2) @(posedge rclk);
    #1;
    compare_all("reset");
    @(negedge rclk);
    arst = 1'b0;

    $display("[TB] back-to-back table vectors");
    for (int i = 0; i < NV; i++) applyStimulus(i, 1'b1);
    for (int i = 0; i < LAT; i++) applyStimulus(-1, 1'b1);

    $display("[TB] A, bubble, B with a 3-cycle stall mid-flight");
    applyStimulus(2, 1'b1);
    applyStimulus(-1, 1'b1);
    applyStimulus(14, 1'b1);
    applyStimulus(-1, 1'b1);
    applyStimulus(-1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(-1, 1'b0);
    for (int i = 0; i < LAT; i++) applyStimulus(-1, 1'b1);

    $display("[TB] asynchronous reset with tokens in flight");
    for (int i = 0; i < 8; i++) applyStimulus(i, 1'b1);
    check_val("valid before reset", int'(bus.out_vld), 1);
    #2;
    arst  = 1'b1;
    #1;
    x_vld = 1'b0;
    x_exp = '0;
    x_of  = 1'b0;
    x_uf  = 1'b0;
    compare_all("async reset");
    bus.step   = 1'b1;
    bus.in_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge rclk);
      #1;
      compare_all("in reset");
    end
    @(negedge rclk);
    arst = 1'b0;
    sb_q.delete();
    hist_floor = edge_n;
    for (int i = 0; i < LAT + 2; i++) applyStimulus(-1, 1'b1);
    applyStimulus(5, 1'b1);
    for (int i = 0; i < LAT; i++) applyStimulus(-1, 1'b1);

    check_val("scoreboard drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
